// File: rtl/cam_capture_writer.sv
// Camera frame capture: decimates an 8-bit RGB565 byte stream and writes kept pixels to a FIFO.
// Define CAM_TEST_PATTERN_EN to replace camera data with a position-derived test pattern.
module cam_capture_writer #(
    parameter int H_STEP = 10,
    parameter int V_STEP = 7,
    parameter int OUT_W  = 64,
    parameter int OUT_H  = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_get,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic        i_pixValid,
    input  logic [7:0]  i_camData,
    input  logic        i_fifoFull,
    output logic        o_wrReqFifo,
    output logic [15:0] o_dataFifo,
    output logic        o_process,
    output logic        o_complete,
    output logic        o_overflow,
    output logic [12:0] o_pixelCount
);
    localparam int HC_W = (H_STEP > 1) ? $clog2(H_STEP) : 1;
    localparam int VC_W = (V_STEP > 1) ? $clog2(V_STEP) : 1;
    localparam int OC_W = $clog2(OUT_W + 1);
    localparam int OR_W = $clog2(OUT_H + 1);

    localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_STEP - 1);
    localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_STEP - 1);
    localparam logic [OC_W-1:0] OUT_W_LIM = OC_W'(OUT_W);
    localparam logic [OR_W-1:0] OUT_H_LIM = OR_W'(OUT_H);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] WAIT_SOF = 3'd2;
    localparam logic [2:0] CAPTURE  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]      state;
    logic            vsync_prev;
    logic            href_prev;
    logic            phase;
    logic            line_kept;
    logic [7:0]      hi_byte;
    logic [HC_W-1:0] col_mod;
    logic [VC_W-1:0] line_mod;
    logic [OC_W-1:0] out_col;
    logic [OR_W-1:0] out_row;

    logic            vsync_rise;
    logic            vsync_fall;
    logic            href_fall;
    logic            keep;
    logic [15:0]     pixel;
`ifdef CAM_TEST_PATTERN_EN
    logic [15:0]     col_ext;
    logic [15:0]     row_ext;
`endif

    always_comb begin
        vsync_rise = i_vsync & ~vsync_prev;
        vsync_fall = ~i_vsync & vsync_prev;
        href_fall  = ~i_href & href_prev;
        keep       = i_href && i_pixValid && phase &&
                     (col_mod == '0) && (line_mod == '0) &&
                     (out_col < OUT_W_LIM) && (out_row < OUT_H_LIM);
        o_process  = (state == ARM) || (state == WAIT_SOF) || (state == CAPTURE);
`ifdef CAM_TEST_PATTERN_EN
        col_ext    = 16'(out_col);
        row_ext    = 16'(out_row);
        pixel      = {col_ext[4:0], row_ext[5:0], col_ext[4:0]};
`else
        pixel      = {hi_byte, i_camData};
`endif
    end

    // High byte holder is pure data; it is always rewritten before use.
    always_ff @(posedge i_clk) begin
        if (state == CAPTURE && i_href && i_pixValid && !phase)
            hi_byte <= i_camData;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            vsync_prev   <= 1'b0;
            href_prev    <= 1'b0;
            phase        <= 1'b0;
            line_kept    <= 1'b0;
            col_mod      <= '0;
            line_mod     <= '0;
            out_col      <= '0;
            out_row      <= '0;
            o_wrReqFifo  <= 1'b0;
            o_dataFifo   <= 16'd0;
            o_complete   <= 1'b0;
            o_overflow   <= 1'b0;
            o_pixelCount <= 13'd0;
        end else begin
            vsync_prev  <= i_vsync;
            href_prev   <= i_href;
            o_wrReqFifo <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_get) begin
                        state        <= ARM;
                        o_complete   <= 1'b0;
                        o_overflow   <= 1'b0;
                        o_pixelCount <= 13'd0;
                        phase        <= 1'b0;
                        line_kept    <= 1'b0;
                        col_mod      <= '0;
                        line_mod     <= '0;
                        out_col      <= '0;
                        out_row      <= '0;
                    end
                end
                ARM: begin
                    // Waiting for vsync high guarantees we never start inside a running frame.
                    if (i_vsync)
                        state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (vsync_fall) begin
                        state     <= CAPTURE;
                        phase     <= 1'b0;
                        line_kept <= 1'b0;
                        col_mod   <= '0;
                        line_mod  <= '0;
                        out_col   <= '0;
                        out_row   <= '0;
                    end
                end
                CAPTURE: begin
                    if (out_row == OUT_H_LIM || vsync_rise) begin
                        state      <= DONE;
                        o_complete <= 1'b1;
                        phase      <= 1'b0;
                    end else if (!i_href) begin
                        phase   <= 1'b0;
                        col_mod <= '0;
                        if (href_fall) begin
                            line_mod  <= (line_mod == V_LAST) ? '0 : line_mod + 1'b1;
                            out_col   <= '0;
                            line_kept <= 1'b0;
                            if (line_kept)
                                out_row <= out_row + 1'b1;
                        end
                    end else if (i_pixValid) begin
                        phase <= ~phase;
                        if (phase) begin
                            col_mod <= (col_mod == H_LAST) ? '0 : col_mod + 1'b1;
                            if (keep) begin
                                // A dropped pixel still consumes its output slot.
                                out_col   <= out_col + 1'b1;
                                line_kept <= 1'b1;
                                if (i_fifoFull) begin
                                    o_overflow <= 1'b1;
                                end else begin
                                    o_wrReqFifo  <= 1'b1;
                                    o_dataFifo   <= pixel;
                                    o_pixelCount <= o_pixelCount + 13'd1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_capture_writer.sv
// Bench for cam_capture_writer: randomized camera frames against a decimation reference model.
// Uses a reduced geometry so full frames stay short.
module tb_cam_capture_writer;
    localparam int HS   = 3;
    localparam int VS   = 2;
    localparam int OW   = 8;
    localparam int OH   = 8;
    localparam int NCOL = 26;
    localparam int NLIN = 18;
    localparam int FULL_FRAME = OW * OH;

    logic        clk = 1'b0;
    logic        rst;
    logic        get;
    logic        vsync;
    logic        href;
    logic        pix_valid;
    logic [7:0]  cam_data;
    logic        fifo_full;
    logic        wr_req;
    logic [15:0] data_fifo;
    logic        process;
    logic        complete;
    logic        overflow;
    logic [12:0] pixel_count;

    int tests = 0;
    int fails = 0;
    int full_left = 0;
    int get_line = -1;
    bit force_first = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    cam_capture_writer #(
        .H_STEP(HS), .V_STEP(VS), .OUT_W(OW), .OUT_H(OH)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_get(get),
        .i_vsync(vsync),
        .i_href(href),
        .i_pixValid(pix_valid),
        .i_camData(cam_data),
        .i_fifoFull(fifo_full),
        .o_wrReqFifo(wr_req),
        .o_dataFifo(data_fifo),
        .o_process(process),
        .o_complete(complete),
        .o_overflow(overflow),
        .o_pixelCount(pixel_count)
    );

    always @(negedge clk) begin
        if (wr_req === 1'b1)
            got_q.push_back(data_fifo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_get();
        get = 1'b1;
        tick();
        get = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic full);
        int gap;
        gap = $urandom_range(0, 2);
        pix_valid = 1'b0;
        repeat (gap) tick();
        pix_valid = 1'b1;
        cam_data  = d;
        fifo_full = full;
        tick();
        pix_valid = 1'b0;
    endtask

    // model_on=0 means the DUT is expected to ignore this line entirely
    task automatic send_line(input int l, input bit model_on);
        logic [7:0] hi;
        logic [7:0] lo;
        logic       full;
        bit         kept;
        bit         first;
        if (l == get_line)
            pulse_get();
        href = 1'b1;
        tick();
        for (int c = 0; c < NCOL; c++) begin
            kept  = model_on && (l % VS == 0) && (c % HS == 0) && (c / HS < OW) && (l / VS < OH);
            first = force_first && (l == 0) && (c == 0);
            full  = 1'b0;
            if (kept && full_left > 0) begin
                full = 1'b1;
                full_left--;
            end else if (!kept) begin
                full = 1'($urandom_range(0, 1));
            end
            hi = first ? 8'hF8 : 8'($urandom);
            lo = first ? 8'h1F : 8'($urandom);
            send_byte(hi, 1'($urandom_range(0, 1)));
            send_byte(lo, full);
            if (first) begin
                chk("first_wr", 32'(wr_req), 32'd1);
                chk("first_data", 32'(data_fifo), 32'hF81F);
                force_first = 1'b0;
            end
            if (kept && !full)
                exp_q.push_back({hi, lo});
        end
        href = 1'b0;
        fifo_full = 1'b0;
        repeat (3) tick();
    endtask

    task automatic sof();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic eof();
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic frame(input int nlines, input bit end_vsync);
        sof();
        for (int l = 0; l < nlines; l++)
            send_line(l, 1'b1);
        if (end_vsync)
            eof();
    endtask

    task automatic check_frame(input string tag, input int exp_cnt, input logic exp_ovf);
        chk({tag, "_model_cnt"}, 32'(exp_q.size()), 32'(exp_cnt));
        chk({tag, "_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_pixel"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_pixcount"}, 32'(pixel_count), 32'(exp_cnt));
        chk({tag, "_complete"}, 32'(complete), 32'd1);
        chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_process"}, 32'(process), 32'd0);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1; get = 1'b0; vsync = 1'b0; href = 1'b0;
        pix_valid = 1'b0; cam_data = 8'd0; fifo_full = 1'b0;
        repeat (3) tick();
        chk("rst_wr", 32'(wr_req), 32'd0);
        chk("rst_data", 32'(data_fifo), 32'd0);
        chk("rst_process", 32'(process), 32'd0);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_count", 32'(pixel_count), 32'd0);
        rst = 1'b0;
        tick();

        // full frame, first pixel directed, FIFO never full
        pulse_get();
        chk("arm_process", 32'(process), 32'd1);
        force_first = 1'b1;
        frame(NLIN, 1'b1);
        check_frame("full", FULL_FRAME, 1'b0);

        // ten kept pixels hit a full FIFO
        pulse_get();
        chk("get_clears_complete", 32'(complete), 32'd0);
        full_left = 10;
        frame(NLIN, 1'b1);
        check_frame("ovf", FULL_FRAME - 10, 1'b1);

        // request arrives mid-frame: nothing until the next start of frame
        for (int l = 0; l < 3; l++) send_line(l, 1'b0);
        pulse_get();
        for (int l = 3; l < 7; l++) send_line(l, 1'b0);
        chk("midget_nowrites", 32'(got_q.size()), 32'd0);
        chk("midget_process", 32'(process), 32'd1);
        get_line = 5;
        frame(NLIN, 1'b1);
        get_line = -1;
        check_frame("midget", FULL_FRAME, 1'b0);

        // reset in the middle of a capture
        pulse_get();
        sof();
        for (int l = 0; l < 3; l++) send_line(l, 1'b1);
        chk("prerst_writes", 32'(got_q.size()), 32'(2 * OW));
        chk("prerst_match", 32'(got_q.size()), 32'(exp_q.size()));
        exp_q.delete();
        got_q.delete();
        rst = 1'b1;
        tick();
        chk("midrst_wr", 32'(wr_req), 32'd0);
        chk("midrst_data", 32'(data_fifo), 32'd0);
        chk("midrst_process", 32'(process), 32'd0);
        chk("midrst_count", 32'(pixel_count), 32'd0);
        chk("midrst_complete", 32'(complete), 32'd0);
        rst = 1'b0;
        for (int l = 3; l < 6; l++) send_line(l, 1'b0);
        eof();
        sof();
        for (int l = 0; l < 4; l++) send_line(l, 1'b0);
        chk("idle_nowrites", 32'(got_q.size()), 32'd0);
        chk("idle_process", 32'(process), 32'd0);
        pulse_get();
        frame(NLIN, 1'b1);
        check_frame("afterrst", FULL_FRAME, 1'b0);

        // vsync rises after three output rows: truncated frame
        pulse_get();
        frame(3 * VS, 1'b0);
        vsync = 1'b1;
        repeat (3) tick();
        check_frame("trunc", 3 * OW, 1'b0);
        vsync = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
